// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag-index definitions for the multi-cycle ALU.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Build macro ALU_MC_MUL_EN adds the MUL state.
package alu_pkg;

    // 4-bit opcode space; codes 10..15 are undefined and complete with err=1
    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_SHL   = 4'd2,
        OP_SHR   = 4'd3,
        OP_SAR   = 4'd4,
        OP_AND   = 4'd5,
        OP_OR    = 4'd6,
        OP_XOR   = 4'd7,
        OP_EQUAL = 4'd8,
        OP_MUL   = 4'd9
    } op_e;

`ifdef ALU_MC_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
`endif

    // bit positions inside the 4-bit flags word {Z, N, C, V}
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mc_if.sv
// Request/result bus of the multi-cycle ALU: valid/ready request in, valid/ready result out.
// Latency: n/a (wiring only).
// Backpressure: master holds request until in_ready; slave holds result until out_ready.
interface alu_mc_if #(parameter int WORD_SIZE = 16);
    logic                 in_valid;
    logic                 in_ready;
    logic [WORD_SIZE-1:0] a;
    logic [WORD_SIZE-1:0] b;
    logic [3:0]           op;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] result;
    logic [3:0]           flags;
    logic                 err;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, flags, err
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, flags, err
    );
endinterface

// File: rtl/alu_shifter.sv
// One-bit shift step (SHL / SHR / SAR) that also reports the bit shifted out.
// Latency: combinational; the caller registers the stepped value.
// Backpressure: none (pure function of its inputs).
module alu_shifter #(
    parameter int WORD_SIZE = 16
) (
    input  logic [WORD_SIZE-1:0] din,
    input  logic                 left,
    input  logic                 arith,
    output logic [WORD_SIZE-1:0] dout,
    output logic                 sout
);

    // left shifts drop the MSB; right shifts drop the LSB and fill with 0 or the sign
    always_comb begin
        if (left) begin
            dout = {din[WORD_SIZE-2:0], 1'b0};
            sout = din[WORD_SIZE-1];
        end else begin
            dout = {arith & din[WORD_SIZE-1], din[WORD_SIZE-1:1]};
            sout = din[0];
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: 1-cycle logic/arith ops, 1-bit-per-cycle shifts, optional shift-add MUL (ALU_MC_MUL_EN).
// Latency: 1 cycle; shifts max(n,1) with n=min(b,WORD_SIZE); MUL WORD_SIZE cycles; undefined ops 1.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, no new request meanwhile.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WORD_SIZE = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mc_if.slave  bus
);

    localparam int CW = $clog2(WORD_SIZE + 1);

    function automatic logic [3:0] mk_flags(input logic [WORD_SIZE-1:0] r, input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_Z] = (r == '0);
        f[FLAG_N] = r[WORD_SIZE-1];
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

    state_e               state_q, state_d;
    logic [WORD_SIZE-1:0] res_q, res_d;
    logic [3:0]           flg_q, flg_d;
    logic                 err_q, err_d;
    logic [3:0]           op_q, op_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                 idle;
    logic [3:0]           cur_op;
    logic [WORD_SIZE-1:0] sh_in, sh_out;
    logic                 sh_bit;
    logic [CW-1:0]        n_cnt;
    logic [WORD_SIZE:0]   add_w, sub_w;
    logic                 add_v, sub_v;

    assign idle   = (state_q == S_IDLE);
    // the acceptance edge already performs the first shift step, so feed the live operand in IDLE
    assign cur_op = idle ? bus.op : op_q;
    assign sh_in  = idle ? bus.a  : res_q;
    assign n_cnt  = (bus.b > WORD_SIZE'(WORD_SIZE)) ? CW'(WORD_SIZE) : bus.b[CW-1:0];

    assign add_w = {1'b0, bus.a} + {1'b0, bus.b};
    assign sub_w = {1'b0, bus.a} - {1'b0, bus.b};
    assign add_v = (bus.a[WORD_SIZE-1] == bus.b[WORD_SIZE-1]) && (add_w[WORD_SIZE-1] != bus.a[WORD_SIZE-1]);
    assign sub_v = (bus.a[WORD_SIZE-1] != bus.b[WORD_SIZE-1]) && (sub_w[WORD_SIZE-1] != bus.a[WORD_SIZE-1]);

    alu_shifter #(.WORD_SIZE(WORD_SIZE)) u_shifter (
        .din   (sh_in),
        .left  (cur_op == OP_SHL),
        .arith (cur_op == OP_SAR),
        .dout  (sh_out),
        .sout  (sh_bit)
    );

`ifdef ALU_MC_MUL_EN
    // shift-add multiply: {hi, lo} starts as {0, b}; res_q doubles as the low half
    logic [WORD_SIZE-1:0] hi_q, hi_d, mc_q, mc_d;
    logic [WORD_SIZE-1:0] m_hi_in, m_lo_in, m_mc, m_hi_nx, m_lo_nx;
    logic [WORD_SIZE:0]   m_sum;

    assign m_hi_in = idle ? '0    : hi_q;
    assign m_lo_in = idle ? bus.b : res_q;
    assign m_mc    = idle ? bus.a : mc_q;
    assign m_sum   = {1'b0, m_hi_in} + (m_lo_in[0] ? {1'b0, m_mc} : '0);
    assign m_hi_nx = m_sum[WORD_SIZE:1];
    assign m_lo_nx = {m_sum[0], m_lo_in[WORD_SIZE-1:1]};
`endif

    assign bus.in_ready  = idle;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = res_q;
    assign bus.flags     = flg_q;
    assign bus.err       = err_q;

    // next-state and datapath updates for every state
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        flg_d   = flg_q;
        err_d   = err_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
`ifdef ALU_MC_MUL_EN
        hi_d    = hi_q;
        mc_d    = mc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_d    = bus.op;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                    case (bus.op)
                        OP_ADD: begin
                            res_d = add_w[WORD_SIZE-1:0];
                            flg_d = mk_flags(add_w[WORD_SIZE-1:0], add_w[WORD_SIZE], add_v);
                        end
                        OP_SUB: begin
                            res_d = sub_w[WORD_SIZE-1:0];
                            flg_d = mk_flags(sub_w[WORD_SIZE-1:0], sub_w[WORD_SIZE], sub_v);
                        end
                        OP_AND: begin
                            res_d = bus.a & bus.b;
                            flg_d = mk_flags(bus.a & bus.b, 1'b0, 1'b0);
                        end
                        OP_OR: begin
                            res_d = bus.a | bus.b;
                            flg_d = mk_flags(bus.a | bus.b, 1'b0, 1'b0);
                        end
                        OP_XOR: begin
                            res_d = bus.a ^ bus.b;
                            flg_d = mk_flags(bus.a ^ bus.b, 1'b0, 1'b0);
                        end
                        OP_EQUAL: begin
                            res_d = {{(WORD_SIZE-1){1'b0}}, (bus.a == bus.b)};
                            flg_d = mk_flags({{(WORD_SIZE-1){1'b0}}, (bus.a == bus.b)}, 1'b0, 1'b0);
                        end
                        OP_SHL, OP_SHR, OP_SAR: begin
                            if (n_cnt == 0) begin
                                res_d = bus.a;
                                flg_d = mk_flags(bus.a, 1'b0, 1'b0);
                            end else begin
                                res_d = sh_out;
                                flg_d = mk_flags(sh_out, sh_bit, 1'b0);
                                if (n_cnt != 1) begin
                                    cnt_d   = n_cnt - 1;
                                    state_d = S_SHIFT;
                                end
                            end
                        end
`ifdef ALU_MC_MUL_EN
                        OP_MUL: begin
                            hi_d    = m_hi_nx;
                            res_d   = m_lo_nx;
                            mc_d    = bus.a;
                            cnt_d   = CW'(WORD_SIZE - 1);
                            state_d = S_MUL;
                        end
`endif
                        default: begin
                            res_d = '0;
                            err_d = 1'b1;
                            flg_d = mk_flags('0, 1'b0, 1'b0);
                        end
                    endcase
                end
            end
            S_SHIFT: begin
                res_d = sh_out;
                cnt_d = cnt_q - 1;
                if (cnt_q == 1) begin
                    flg_d   = mk_flags(sh_out, sh_bit, 1'b0);
                    state_d = S_DONE;
                end
            end
`ifdef ALU_MC_MUL_EN
            S_MUL: begin
                hi_d  = m_hi_nx;
                res_d = m_lo_nx;
                cnt_d = cnt_q - 1;
                if (cnt_q == 1) begin
                    flg_d   = mk_flags(m_lo_nx, |m_hi_nx, 1'b0);
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // datapath registers: result, flags, err, captured opcode and step counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            flg_q <= '0;
            err_q <= 1'b0;
            op_q  <= '0;
            cnt_q <= '0;
`ifdef ALU_MC_MUL_EN
            hi_q  <= '0;
            mc_q  <= '0;
`endif
        end else begin
            res_q <= res_d;
            flg_q <= flg_d;
            err_q <= err_d;
            op_q  <= op_d;
            cnt_q <= cnt_d;
`ifdef ALU_MC_MUL_EN
            hi_q  <= hi_d;
            mc_q  <= mc_d;
`endif
        end
    end

endmodule
